// File: rtl/alu_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl_if
//   Bundles every non-clock signal of alu_share_ctrl:
//     - two request channels  (reqN_valid/ready, reqN_a/b/op)
//     - two response channels (rspN_valid/ready, rspN_data/ovf)
//     - the shared-ALU port   (alu_a/b/op out, alu_out/alu_ovf in)
//     - status                (busy, ovf_count)
//   modport slave  : the controller.
//   modport master : the surroundings (requesters plus the ALU instance).
// -----------------------------------------------------------------------------
interface alu_share_ctrl_if #(
    parameter int DATA_W    = 4,
    parameter int OVF_CNT_W = 8
);
    // requester 0
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [2:0]        req0_op;
    logic              rsp0_valid;
    logic              rsp0_ready;
    logic [DATA_W-1:0] rsp0_data;
    logic              rsp0_ovf;
    // requester 1
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [2:0]        req1_op;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp1_data;
    logic              rsp1_ovf;
    // shared ALU
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ovf;
    // status
    logic                 busy;
    logic [OVF_CNT_W-1:0] ovf_count;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        input  alu_out, alu_ovf,
        output req0_ready, rsp0_valid, rsp0_data, rsp0_ovf,
        output req1_ready, rsp1_valid, rsp1_data, rsp1_ovf,
        output alu_a, alu_b, alu_op, busy, ovf_count
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        output alu_out, alu_ovf,
        input  req0_ready, rsp0_valid, rsp0_data, rsp0_ovf,
        input  req1_ready, rsp1_valid, rsp1_data, rsp1_ovf,
        input  alu_a, alu_b, alu_op, busy, ovf_count
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//   Round-robin sharing of one combinational ALU between two requesters.
//   One operation at a time: IDLE (arbitrate/accept) -> EXEC (ALU evaluates
//   registered operands) -> RESP (hold result until the owner consumes it).
//   Three cycles per operation when the response is consumed immediately.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : synchronous reset, active low
//   bus    : alu_share_ctrl_if.slave (request/response channels, ALU port,
//            busy, saturating overflow-event counter ovf_count)
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int DATA_W    = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Per-requester views packed by requester index
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             rsp_ready;
    logic [1:0]             rsp_valid;
    logic [1:0][DATA_W-1:0] req_a;
    logic [1:0][DATA_W-1:0] req_b;
    logic [1:0][2:0]        req_op;

    logic                   sel;      // requester granted if it is valid
    logic                   last;     // requester served most recently
    logic                   owner;    // requester of the in-flight op
    logic                   accept;
    logic                   consume;

    logic [DATA_W-1:0]      alu_a_q;
    logic [DATA_W-1:0]      alu_b_q;
    logic [2:0]             alu_op_q;
    logic [DATA_W-1:0]      rsp_data_q;
    logic                   rsp_ovf_q;
    logic [OVF_CNT_W-1:0]   ovf_cnt_q;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_a     = {bus.req1_a,  bus.req0_a};
    assign req_b     = {bus.req1_b,  bus.req0_b};
    assign req_op    = {bus.req1_op, bus.req0_op};

    // Arbitration: a lone requester wins; on a tie the one not served last.
    always_comb begin
        sel = 1'b0;
        case (req_valid)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last;
            default: sel = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state and handshake decode. rsp_ready only affects the
    // RESP->IDLE transition, never req_ready in the same cycle.
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        accept    = 1'b0;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                // rst_n gate keeps ready low while reset is asserted
                if (rst_n && req_valid[sel]) begin
                    req_ready[sel] = 1'b1;
                    accept         = 1'b1;
                    state_nxt      = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (rsp_ready[owner]) begin
                    consume   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: ALU operand registers, response capture, overflow counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last       <= 1'b1;          // req0 wins the first tie
            owner      <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
            rsp_ovf_q  <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            if (accept) begin
                alu_a_q  <= req_a[sel];
                alu_b_q  <= req_b[sel];
                alu_op_q <= req_op[sel];
                owner    <= sel;
            end
            // Operands have been stable for a full cycle in EXEC; the ALU
            // output is captured at its end. Unused opcodes go through as-is.
            if (state == EXEC) begin
                rsp_data_q <= bus.alu_out;
                rsp_ovf_q  <= bus.alu_ovf;
                if (bus.alu_ovf && (ovf_cnt_q != {OVF_CNT_W{1'b1}}))
                    ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
            end
            if (consume)
                last <= owner;
        end
    end

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    // Only the owner's valid is high, so both data ports share one register
    assign bus.rsp0_data  = rsp_data_q;
    assign bus.rsp1_data  = rsp_data_q;
    assign bus.rsp0_ovf   = rsp_ovf_q;
    assign bus.rsp1_ovf   = rsp_ovf_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.busy       = (state != IDLE);
    assign bus.ovf_count  = ovf_cnt_q;

    // Protocol sanity
    a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(req_ready[0] && req_ready[1]));
    a_rsp_hold  : assert property (@(posedge clk) disable iff (!rst_n)
        (state == RESP && !rsp_ready[owner]) |=> (state == RESP && $stable(rsp_data_q)
                                                  && $stable(rsp_ovf_q)));

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_share_ctrl_if #(.DATA_W(4), .OVF_CNT_W(8)) bus ();

    alu_share_ctrl #(.DATA_W(4), .OVF_CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU instance modelled at bit level
    logic [3:0] alu_t;
    always_comb begin
        alu_t       = 4'd0;
        bus.alu_ovf = 1'b0;
        case (bus.alu_op)
            3'd0: begin
                alu_t       = bus.alu_a + bus.alu_b;
                bus.alu_ovf = (bus.alu_a[3] == bus.alu_b[3]) && (alu_t[3] != bus.alu_a[3]);
            end
            3'd1: begin
                alu_t       = bus.alu_a - bus.alu_b;
                bus.alu_ovf = (bus.alu_a[3] != bus.alu_b[3]) && (alu_t[3] != bus.alu_a[3]);
            end
            3'd2:    alu_t = bus.alu_a & bus.alu_b;
            3'd3:    alu_t = bus.alu_a | bus.alu_b;
            3'd4:    alu_t = bus.alu_a ^ bus.alu_b;
            default: alu_t = 4'd0;
        endcase
        bus.alu_out = alu_t;
    end

    // Reference: signed integer arithmetic, overflow = result out of [-8,7]
    function automatic void ref_alu(input logic [3:0] a, input logic [3:0] b,
                                    input logic [2:0] op,
                                    output logic [3:0] r, output logic o);
        int sa, sb, s;
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        s  = 0;
        r  = 4'd0;
        o  = 1'b0;
        case (op)
            3'd0: begin s = sa + sb; r = s[3:0]; o = (s > 7) || (s < -8); end
            3'd1: begin s = sa - sb; r = s[3:0]; o = (s > 7) || (s < -8); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: r = 4'd0;
        endcase
    endfunction

    typedef struct {
        int         who;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } txn_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0; bus.rsp0_ready = 0;
        bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0; bus.rsp1_ready = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for a grant; returns at the negedge where ready is seen
    task automatic wait_grant(output int who, output bit ok);
        who = -1;
        ok  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin who = 0; ok = 1; break; end
            if (bus.req1_ready) begin who = 1; ok = 1; break; end
            step();
        end
    endtask

    // Called right after the accepting edge; lat counts cycles to rsp_valid
    task automatic wait_rsp(input int n, output logic [3:0] d, output logic o,
                            output bit ok, output int lat);
        ok = 0; lat = 0; d = 'x; o = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (n == 0 && bus.rsp0_valid) begin d = bus.rsp0_data; o = bus.rsp0_ovf; ok = 1; break; end
            if (n == 1 && bus.rsp1_valid) begin d = bus.rsp1_data; o = bus.rsp1_ovf; ok = 1; break; end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.req0_valid = 1; bus.req1_valid = 1; bus.req0_a = 4'h3; bus.req1_b = 4'h5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp0_valid, bus.rsp1_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {bus.req0_ready, bus.req1_ready, bus.busy, bus.rsp0_valid, bus.rsp1_valid});
        end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 11'd0) begin
            errors++; $display("FAIL reset_alu got=%h/%h/%h exp=0", bus.alu_a, bus.alu_b, bus.alu_op);
        end
        checks++;
        if ({bus.rsp0_data, bus.rsp0_ovf, bus.rsp1_data, bus.rsp1_ovf} !== 10'd0) begin
            errors++; $display("FAIL reset_rsp got=%h %b %h %b exp=0",
                               bus.rsp0_data, bus.rsp0_ovf, bus.rsp1_data, bus.rsp1_ovf);
        end
        checks++;
        if (bus.ovf_count !== 8'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.ovf_count);
        end
        clear_inputs();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int who, lat; bit ok; logic [3:0] d; logic o;
        apply_reset();
        bus.req0_a = 4'b0111; bus.req0_b = 4'b0001; bus.req0_op = 3'b000;
        bus.req0_valid = 1; bus.rsp0_ready = 1;
        wait_grant(who, ok);
        checks++;
        if (!ok || who != 0) begin errors++; $display("FAIL basic_grant got=%0d exp=0", who); end
        step();
        bus.req0_valid = 0;
        wait_rsp(0, d, o, ok, lat);
        checks++;
        if (!ok || lat != 2) begin errors++; $display("FAIL basic_latency got=%0d exp=2", lat); end
        checks++;
        if ({d, o} !== {4'b1000, 1'b1}) begin
            errors++; $display("FAIL basic_data got=%b/%b exp=1000/1", d, o);
        end
        checks++;
        if (bus.ovf_count !== 8'd1) begin errors++; $display("FAIL basic_cnt got=%0d exp=1", bus.ovf_count); end
        step();
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.rsp0_valid} !== 2'b00) begin
            errors++; $display("FAIL basic_idle got=%b exp=00", {bus.busy, bus.rsp0_valid});
        end
    endtask

    task automatic test_tie();
        int who, lat; bit ok; logic [3:0] d, r; logic o, ro;
        apply_reset();
        bus.req0_a = 4'b1000; bus.req0_b = 4'b1100; bus.req0_op = 3'b010;
        bus.req1_a = 4'b1010; bus.req1_b = 4'b0101; bus.req1_op = 3'b100;
        bus.req0_valid = 1; bus.req1_valid = 1; bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            wait_grant(who, ok);
            checks++;
            if (!ok || who != (i % 2)) begin
                errors++; $display("FAIL tie_grant[%0d] got=%0d exp=%0d", i, who, i % 2);
            end
            if (!ok) break;
            step();
            wait_rsp(who, d, o, ok, lat);
            if (who == 0) ref_alu(4'b1000, 4'b1100, 3'b010, r, ro);
            else          ref_alu(4'b1010, 4'b0101, 3'b100, r, ro);
            checks++;
            if (!ok || {d, o} !== {r, ro}) begin
                errors++; $display("FAIL tie_data[%0d] got=%b/%b exp=%b/%b", i, d, o, r, ro);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_backpressure();
        int who, lat; bit ok; logic [3:0] d; logic o;
        apply_reset();
        bus.req1_a = 4'b1000; bus.req1_b = 4'b0001; bus.req1_op = 3'b001; bus.req1_valid = 1;
        wait_grant(who, ok);
        checks++;
        if (!ok || who != 1) begin errors++; $display("FAIL bp_grant got=%0d exp=1", who); end
        step();
        bus.req1_valid = 0;
        bus.req0_a = 4'd1; bus.req0_b = 4'd2; bus.req0_op = 3'd0; bus.req0_valid = 1; bus.rsp0_ready = 1;
        @(negedge clk);
        checks++;
        if ({bus.req0_ready, bus.rsp1_valid} !== 2'b00) begin
            errors++; $display("FAIL bp_exec got=%b exp=00", {bus.req0_ready, bus.rsp1_valid});
        end
        step();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.rsp1_ready = 1;
            @(negedge clk);
            checks++;
            if ({bus.rsp1_valid, bus.rsp1_data, bus.rsp1_ovf, bus.rsp0_valid, bus.req0_ready}
                !== {1'b1, 4'b0111, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got=%b/%b/%b/%b/%b exp=1/0111/1/0/0", i, bus.rsp1_valid,
                         bus.rsp1_data, bus.rsp1_ovf, bus.rsp0_valid, bus.req0_ready);
            end
            step();
        end
        bus.rsp1_ready = 0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.req0_ready, bus.rsp1_valid} !== 3'b010) begin
            errors++; $display("FAIL bp_idle got=%b exp=010", {bus.busy, bus.req0_ready, bus.rsp1_valid});
        end
        step();
        bus.req0_valid = 0;
        wait_rsp(0, d, o, ok, lat);
        checks++;
        if (!ok || {d, o} !== {4'd3, 1'b0}) begin
            errors++; $display("FAIL bp_next got=%b/%b exp=0011/0", d, o);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_op110();
        int who, lat; bit ok; logic [3:0] d; logic o;
        apply_reset();
        bus.rsp0_ready = 1;
        bus.req0_a = 4'b0111; bus.req0_b = 4'b0111; bus.req0_op = 3'b000; bus.req0_valid = 1;
        wait_grant(who, ok); step(); bus.req0_valid = 0;
        wait_rsp(0, d, o, ok, lat); step();
        bus.req0_a = 4'b1111; bus.req0_b = 4'b1111; bus.req0_op = 3'b110; bus.req0_valid = 1;
        wait_grant(who, ok);
        checks++;
        if (!ok || who != 0) begin errors++; $display("FAIL op110_grant got=%0d exp=0", who); end
        step();
        bus.req0_valid = 0;
        @(negedge clk);
        checks++;
        if (bus.alu_op !== 3'b110) begin errors++; $display("FAIL op110_fwd got=%b exp=110", bus.alu_op); end
        step();
        @(negedge clk);
        checks++;
        if ({bus.rsp0_valid, bus.rsp0_data, bus.rsp0_ovf, bus.ovf_count} !== {1'b1, 4'd0, 1'b0, 8'd1}) begin
            errors++;
            $display("FAIL op110_rsp got=%b/%b/%b cnt=%0d exp=1/0000/0 cnt=1",
                     bus.rsp0_valid, bus.rsp0_data, bus.rsp0_ovf, bus.ovf_count);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_saturate();
        int nrsp, grants, exp;
        apply_reset();
        bus.req0_a = 4'b0111; bus.req0_b = 4'b0111; bus.req0_op = 3'b000;
        bus.req0_valid = 1; bus.rsp0_ready = 1;
        nrsp = 0; grants = 0;
        for (int c = 0; c < 1200 && nrsp < 300; c++) begin
            @(negedge clk);
            if (bus.req0_ready) grants++;
            if (bus.rsp0_valid) begin
                nrsp++;
                if (nrsp inside {1, 254, 255, 256, 300}) begin
                    exp = (nrsp > 255) ? 255 : nrsp;
                    checks++;
                    if (bus.ovf_count !== 8'(exp)) begin
                        errors++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", nrsp, bus.ovf_count, exp);
                    end
                end
            end
            step();
            if (grants >= 300) bus.req0_valid = 0;
        end
        checks++;
        if (nrsp != 300) begin errors++; $display("FAIL sat_done got=%0d exp=300", nrsp); end
        clear_inputs();
    endtask

    task automatic test_reset_exec();
        int who, lat; bit ok; logic [3:0] d; logic o;
        apply_reset();
        bus.req0_a = 4'b0111; bus.req0_b = 4'b0111; bus.req0_op = 3'b000;
        bus.req0_valid = 1; bus.rsp0_ready = 1;
        wait_grant(who, ok);
        step();
        bus.req0_valid = 0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL rexec_busy got=%b exp=1", bus.busy); end
        rst_n = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.req0_ready, bus.req1_ready,
             bus.alu_a, bus.alu_b, bus.alu_op, bus.rsp0_data, bus.rsp0_ovf, bus.ovf_count} !== '0) begin
            errors++;
            $display("FAIL rexec_state got=%b%b%b a=%h b=%h op=%h d=%h o=%b cnt=%0d exp=all 0",
                     bus.rsp0_valid, bus.rsp1_valid, bus.busy, bus.alu_a, bus.alu_b, bus.alu_op,
                     bus.rsp0_data, bus.rsp0_ovf, bus.ovf_count);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.rsp0_valid, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL rexec_norsp got=%b exp=00", {bus.rsp0_valid, bus.busy});
        end
        step();
        bus.req1_a = 4'd2; bus.req1_b = 4'd3; bus.req1_op = 3'd0; bus.req1_valid = 1; bus.rsp1_ready = 1;
        wait_grant(who, ok);
        step();
        bus.req1_valid = 0;
        wait_rsp(1, d, o, ok, lat);
        checks++;
        if (!ok || lat != 2 || {d, o} !== {4'd5, 1'b0}) begin
            errors++; $display("FAIL rexec_next got=%b/%b lat=%0d exp=0101/0 lat=2", d, o, lat);
        end
        step();
        clear_inputs();
    endtask

    // Random traffic against a transaction-level model: grant rule, 2-cycle
    // response latency, payload integrity, saturating overflow count.
    task automatic test_random();
        txn_t       pend[$];
        txn_t       t;
        int         age, win, m_last, m_cnt;
        logic [1:0] exp_r, exp_v;
        logic [3:0] r, gd;
        logic       o, go;
        apply_reset();
        age = 0; m_last = 1; m_cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            if (pend.size() != 0) age++;
            exp_r = 2'b00;
            win   = 0;
            if (pend.size() == 0 && (bus.req0_valid || bus.req1_valid)) begin
                if (bus.req0_valid && bus.req1_valid) win = (m_last == 0) ? 1 : 0;
                else                                  win = bus.req1_valid ? 1 : 0;
                exp_r[win] = 1'b1;
            end
            checks++;
            if ({bus.req1_ready, bus.req0_ready} !== exp_r) begin
                errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc,
                                   {bus.req1_ready, bus.req0_ready}, exp_r);
            end
            exp_v = 2'b00;
            if (pend.size() != 0 && age >= 2) begin
                exp_v[pend[0].who] = 1'b1;
                ref_alu(pend[0].a, pend[0].b, pend[0].op, r, o);
                if (age == 2 && o && m_cnt < 255) m_cnt++;
            end
            checks++;
            if ({bus.rsp1_valid, bus.rsp0_valid} !== exp_v) begin
                errors++; $display("FAIL rnd_rspv cyc=%0d got=%b exp=%b", cyc,
                                   {bus.rsp1_valid, bus.rsp0_valid}, exp_v);
            end
            checks++;
            if (bus.ovf_count !== 8'(m_cnt)) begin
                errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.ovf_count, m_cnt);
            end
            if (exp_v != 2'b00) begin
                gd = (pend[0].who == 1) ? bus.rsp1_data : bus.rsp0_data;
                go = (pend[0].who == 1) ? bus.rsp1_ovf  : bus.rsp0_ovf;
                checks++;
                if ({gd, go} !== {r, o}) begin
                    errors++; $display("FAIL rnd_data cyc=%0d got=%b/%b exp=%b/%b", cyc, gd, go, r, o);
                end
                if ((pend[0].who == 1) ? bus.rsp1_ready : bus.rsp0_ready) begin
                    m_last = pend[0].who;
                    void'(pend.pop_front());
                end
            end
            if (exp_r != 2'b00) begin
                t.who = win;
                t.a   = win ? bus.req1_a  : bus.req0_a;
                t.b   = win ? bus.req1_b  : bus.req0_b;
                t.op  = win ? bus.req1_op : bus.req0_op;
                pend.push_back(t);
                age = 0;
            end
            step();
            // A requester re-rolls only once its pending offer was taken
            if (exp_r[0] || !bus.req0_valid) begin
                bus.req0_valid = ($urandom_range(0, 2) != 0);
                bus.req0_a  = 4'($urandom_range(0, 15));
                bus.req0_b  = 4'($urandom_range(0, 15));
                bus.req0_op = 3'($urandom_range(0, 7));
            end
            if (exp_r[1] || !bus.req1_valid) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_a  = 4'($urandom_range(0, 15));
                bus.req1_b  = 4'($urandom_range(0, 15));
                bus.req1_op = 3'($urandom_range(0, 7));
            end
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
        end
        clear_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_op110();
        test_saturate();
        test_reset_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Round-robin scheduler that shares one 4-bit combinational ALU (ops ADD/SUB/AND/OR/XOR, signed overflow flag) between two requesters. Each requester offers an operand pair and opcode over a valid/ready channel and receives the result and overflow flag over a separate valid/ready response channel. The block drives the shared ALU's inputs from registers, captures its outputs, and keeps a saturating count of overflow events. It sits between the two issuing units and the ALU instance.

## Interface
- DATA_W, 4, operand/result width; must match the ALU width.
- OVF_CNT_W, 8, width of the overflow event counter.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- req0_valid / req1_valid  in  1  request offered by requester 0 / 1
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
- req0_op / req1_op  in  3  opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor, others give result 0
- req0_ready / req1_ready  out  1  request accepted this cycle when high with valid
- rsp0_valid / rsp1_valid  out  1  response available
- rsp0_data / rsp1_data  out  DATA_W  ALU result
- rsp0_ovf / rsp1_ovf  out  1  signed overflow flag
- rsp0_ready / rsp1_ready  in  1  requester consumes response
- alu_a, alu_b  out  DATA_W  to shared ALU
- alu_op  out  3  to shared ALU
- alu_out  in  DATA_W  from shared ALU
- alu_ovf  in  1  from shared ALU
- busy  out  1  high in any state other than IDLE
- ovf_count  out  OVF_CNT_W  saturating count of completed operations with overflow

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: sel = req1 if only req1_valid; req0 if only req0_valid; if both, the requester other than `last`. reqN_ready = (state==IDLE) && (sel==N) && reqN_valid; never both high.
- Handshake reqN_valid && reqN_ready: latch a, b, op into alu_a/alu_b/alu_op registers, store owner = N, go to EXEC.
- EXEC (exactly 1 cycle): ALU inputs stable from registers; at the end of the cycle capture alu_out/alu_ovf into the response registers; if alu_ovf && ovf_count != max, ovf_count += 1; go to RESP.
- RESP: rsp{owner}_valid = 1; the other rsp_valid = 0. Data/ovf held stable until rsp{owner}_ready. On ready: last = owner, go to IDLE.
- No request is accepted outside IDLE; requesters hold valid and payload until ready.
- Opcodes 101–111 are forwarded unchanged; the response is whatever the ALU returns (0, ovf 0) and counts as a normal transaction.
- alu_* registers keep the last operation's values in IDLE.
- ovf_count saturates at 2^OVF_CNT_W−1; it never wraps.

## Timing
- Reset (rst_n low at a clk edge): state IDLE, last = 1 (req0 wins the first tie), alu_a/alu_b/alu_op = 0, rsp0/1_valid = 0, rsp0/1_data = 0, rsp0/1_ovf = 0, ovf_count = 0, busy = 0; req*_ready = 0 during reset.
- Reset in EXEC or RESP abandons the transaction; no response is produced.
- Accept at edge k → EXEC in cycle k+1 → rsp_valid high from cycle k+2.
- With rsp_ready held high: response is consumed at edge k+2 and the next acceptance happens at the earliest at edge k+3 (3 cycles per operation).
- Back-pressure: each cycle of rsp_ready low extends RESP by one cycle; the other requester is stalled.
- ready/valid outputs are registered-state decodes plus the combinational reqN_valid term; no path exists from rsp*_ready to req*_ready within the same cycle.

## Test plan
- Reset, then req0 {a=0111, b=0001, op=000} with rsp0_ready=1 → rsp0_valid in cycle 2 after accept, data 1000, ovf 1, ovf_count 1.
- Both requesters valid immediately after reset (req0 and 1000, 1100 op 010; req1 xor 1010, 0101 op 100) → req0 served first (data 1000, ovf 0), then req1 (data 1111, ovf 0); with both held valid, grants alternate 0,1,0,1.
- req1 sub {1000, 0001, op 001} with rsp1_ready low for 5 cycles → rsp1_valid/data 0111/ovf 1 stable throughout; req0_ready stays 0; IDLE is reached one cycle after ready rises.
- Opcode 110 with {1111, 1111} → data 0000, ovf 0, ovf_count unchanged.
- 300 back-to-back overflowing adds (0111 + 0111) → ovf_count stops at 255 and does not wrap.
- rst_n low during EXEC → no rsp_valid; all outputs at reset values; the next request completes normally.
